// File: rtl/arashi_mem_wr_ctrl.sv
// arashi_mem_wr_ctrl
// Ring-buffer controller between the thread cache/arbiter and an external
// SRAM. Accepted cache words are tagged with their thread id and written at a
// wrapping write pointer; an in-order drain port returns them with a fixed
// two-cycle latency. Occupancy (count) drives back-pressure, while the
// committed count (words physically in SRAM) gates reads.

module arashi_mem_wr_ctrl #(
  parameter int DATA_WIDTH       = 32,
  parameter int MEM_WIDTH        = 10,
  parameter int THREAD_NUM_WIDTH = 2
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   rcache,
  input  logic [THREAD_NUM_WIDTH-1:0]            toread,
  input  logic [DATA_WIDTH-1:0]                  cache2mem,
  output logic                                   stall,
  input  logic                                   flush,
  output logic                                   sram_we,
  output logic [MEM_WIDTH-1:0]                   sram_waddr,
  output logic [DATA_WIDTH+THREAD_NUM_WIDTH-1:0] sram_wdata,
  output logic                                   sram_re,
  output logic [MEM_WIDTH-1:0]                   sram_raddr,
  input  logic [DATA_WIDTH+THREAD_NUM_WIDTH-1:0] sram_rdata,
  input  logic                                   rd_req,
  output logic                                   rd_valid,
  output logic [DATA_WIDTH-1:0]                  rd_data,
  output logic [THREAD_NUM_WIDTH-1:0]            rd_tid,
  output logic [MEM_WIDTH:0]                     count,
  output logic                                   overflow
);

  localparam int              DEPTH = 1 << MEM_WIDTH;
  localparam logic [MEM_WIDTH:0] FULL = (MEM_WIDTH+1)'(DEPTH);
  localparam logic [MEM_WIDTH:0] ONE  = (MEM_WIDTH+1)'(1);

  logic [MEM_WIDTH-1:0]        wptr;
  logic [MEM_WIDTH-1:0]        rptr;
  logic [MEM_WIDTH:0]          committed;
  logic                        wr_acc;
  logic                        rd_acc;
  logic [DATA_WIDTH-1:0]       rd_data_q;
  logic [THREAD_NUM_WIDTH-1:0] rd_tid_q;

  // Full is judged from occupancy alone; pointers may be equal when full or empty.
  // NOTE: continuous assigns and fully-specified expressions cannot infer latches.
  assign stall  = (count == FULL);
  assign wr_acc = rcache && !stall && !flush;
  assign rd_acc = rd_req && (committed != '0) && !flush;

  // The SRAM returns data in the cycle rd_valid is high, so the drained word is
  // passed straight through then and held from a register otherwise.
  assign rd_data = rd_valid ? sram_rdata[DATA_WIDTH-1:0] : rd_data_q;
  assign rd_tid  = rd_valid ? sram_rdata[DATA_WIDTH+THREAD_NUM_WIDTH-1:DATA_WIDTH] : rd_tid_q;

  // Pointers, occupancy, SRAM request stages and sticky overflow.
  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      committed  <= '0;
      overflow   <= 1'b0;
      sram_we    <= 1'b0;
      sram_waddr <= '0;
      sram_wdata <= '0;
      sram_re    <= 1'b0;
      sram_raddr <= '0;
      rd_valid   <= 1'b0;
    end else if (flush) begin
      // Flush empties the ring and cancels every in-flight stage.
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      committed <= '0;
      overflow  <= 1'b0;
      sram_we   <= 1'b0;
      sram_re   <= 1'b0;
      rd_valid  <= 1'b0;
    end else begin
      sram_we <= wr_acc;
      if (wr_acc) begin
        sram_waddr <= wptr;
        sram_wdata <= {toread, cache2mem};
        wptr       <= wptr + MEM_WIDTH'(1);
      end

      sram_re <= rd_acc;
      if (rd_acc) begin
        sram_raddr <= rptr;
        rptr       <= rptr + MEM_WIDTH'(1);
      end

      rd_valid <= sram_re;

      if (rcache && stall) begin
        overflow <= 1'b1;
      end

      // Occupancy counts accepted words.
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase

      // Committed counts words actually written into the SRAM.
      case ({sram_we, rd_acc})
        2'b10:   committed <= committed + ONE;
        2'b01:   committed <= committed - ONE;
        default: committed <= committed;
      endcase
    end
  end

  // Capture each drained word so rd_data/rd_tid hold between pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
      rd_tid_q  <= '0;
    end else if (rd_valid) begin
      rd_data_q <= sram_rdata[DATA_WIDTH-1:0];
      rd_tid_q  <= sram_rdata[DATA_WIDTH+THREAD_NUM_WIDTH-1:DATA_WIDTH];
    end
  end

endmodule

// File: doc/arashi_mem_wr_ctrl.md
Name: arashi_mem_wr_ctrl

Overview:
Ring-buffer controller directly downstream of the thread cache/arbiter pair. It consumes each word released by the cache (rcache strobe, cache2mem data, toread thread id), tags it with its thread id and writes it into a single-port-per-direction SRAM at a wrapping write pointer. It provides an in-order drain port with fixed read latency and back-pressures the arbiter through stall when the buffer is full.

Parameters:
DATA_WIDTH, 32, width of a cache word
MEM_WIDTH, 10, SRAM address width; depth DEPTH = 2^MEM_WIDTH
THREAD_NUM_WIDTH, 2, width of the thread id tag

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
rcache  input  1  cache releases one word this cycle
toread  input  THREAD_NUM_WIDTH  thread id of the released word
cache2mem  input  DATA_WIDTH  released word
stall  output  1  buffer full; arbiter must not assert rcache
flush  input  1  synchronous clear of buffer contents
sram_we  output  1  SRAM write enable
sram_waddr  output  MEM_WIDTH  SRAM write address
sram_wdata  output  DATA_WIDTH+THREAD_NUM_WIDTH  {tid, data}
sram_re  output  1  SRAM read enable
sram_raddr  output  MEM_WIDTH  SRAM read address
sram_rdata  input  DATA_WIDTH+THREAD_NUM_WIDTH  SRAM read data, valid 1 cycle after sram_re
rd_req  input  1  drain request
rd_valid  output  1  drained word valid (1-cycle pulse per word)
rd_data  output  DATA_WIDTH  drained word
rd_tid  output  THREAD_NUM_WIDTH  thread id of drained word
count  output  MEM_WIDTH+1  accepted-word occupancy
overflow  output  1  sticky: rcache arrived while stall was high

Behaviour:
- Reset (rst high, async): wptr=rptr=0, count=0, committed=0, stall=0, overflow=0, sram_we=0, sram_re=0, rd_valid=0, rd_data=0, rd_tid=0, all SRAM address/data outputs 0.
- Write accept: rcache && !stall in cycle N. In cycle N+1 sram_we=1, sram_waddr=wptr, sram_wdata={toread, cache2mem} as sampled at N; wptr increments mod DEPTH after the write.
- count increments at the acceptance edge (end of N); committed increments at the end of N+1 (word physically in SRAM).
- stall = (count == DEPTH), combinational from count.
- rcache while stall=1: word dropped, no SRAM write, overflow set; it stays set until rst or flush.
- Read accept: rd_req && committed>0 in cycle M. In cycle M+1 sram_re=1, sram_raddr=rptr; rptr increments mod DEPTH. In cycle M+2 rd_valid=1, rd_data/rd_tid = sram_rdata fields. Fixed latency 2; back-to-back reads give one rd_valid per cycle.
- count and committed decrement at the read acceptance edge (end of M).
- rd_req while committed==0: ignored, no sram_re, no rd_valid. A word written at N is readable at earliest when rd_req is sampled at N+2.
- Simultaneous write accept and read accept: count unchanged. committed follows its own +1 and -1 rules independently.
- Wrap-around: pointers roll over from DEPTH-1 to 0 silently. Full and empty are decided only by count and committed, never by pointer compare.
- flush (sync, priority over everything): wptr=rptr=count=committed=0, overflow=0. rcache and rd_req in the same cycle are ignored. Any pending sram_we or sram_re stage is cancelled, and any rd_valid that would occur in the next two cycles is suppressed.
- rst mid-operation: all in-flight stages are discarded immediately; outputs take reset values asynchronously.
- rd_data/rd_tid hold their last value when rd_valid=0.

Test Plan:
- Reset then write 3 words (tid 0..2, data 0xA0..0xA2) on consecutive cycles: sram_we high for 3 cycles starting 1 cycle later, waddr 0,1,2, wdata {tid,data}; count=3.
- Drain those 3 with rd_req held: sram_re at raddr 0,1,2; rd_valid pulses on 3 consecutive cycles, 2 cycles after each accept, returning 0xA0/0, 0xA1/1, 0xA2/2; count=0. A 4th rd_req gives no rd_valid.
- MEM_WIDTH=2: write 4 words → stall=1, count=4. A 5th rcache is dropped and overflow=1. Drain 1 → stall=0. Write 1 → it lands at waddr 0 (wrap).
- Write and read accepted in the same cycle at count=2: count stays 2, and the returned data is the oldest word.
- rd_req one cycle after the first-ever write: ignored because committed=0. rd_req two cycles after: accepted.
- flush while one read is in flight: rd_valid never asserts, and count=0, overflow=0, and the pointers are 0 on the next cycle. Assert rst mid-write: sram_we drops immediately.
